// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type and default widths for the instruction fetch front end
package fetch_pkg;

  localparam int PC_W     = 8;
  localparam int INSTR_W  = 9;
  localparam int OFF_W    = 6;
  localparam int START_PC = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - next fetch address: reload, increment, absolute/relative branch or hold
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int PC_W     = fetch_pkg::PC_W,
  parameter int OFF_W    = fetch_pkg::OFF_W,
  parameter int START_PC = fetch_pkg::START_PC
) (
  input  logic              launch,
  input  logic              advance,
  input  logic              redirect,
  input  logic              br_abs,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   instr_pc,
  input  logic [PC_W-1:0]   br_target,
  input  logic [OFF_W-1:0]  br_offset,
  output logic [PC_W-1:0]   next_pc
);

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  logic [PC_W-1:0] offset_ext;

  // START_PC is presented to the ROM during the launch cycle, so the register skips ahead to START_PC+1.
  always_comb begin
    offset_ext = PC_W'($signed(br_offset));
    next_pc    = pc;
    if (launch) begin
      next_pc = START_ADDR + 1'b1;
    end else if (advance) begin
      if (!redirect) begin
        next_pc = pc + 1'b1;
      end else if (br_abs) begin
        next_pc = br_target;
      end else begin
        next_pc = instr_pc + offset_ext;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, ROM driver and start/halt run control for the decode datapath
// Optional perf counters (cycle_cnt, instr_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W     = fetch_pkg::PC_W,
  parameter int INSTR_W  = fetch_pkg::INSTR_W,
  parameter int START_PC = fetch_pkg::START_PC,
  parameter int OFF_W    = fetch_pkg::OFF_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               stall,
  input  logic               br_taken,
  input  logic               br_abs,
  input  logic [PC_W-1:0]    br_target,
  input  logic [OFF_W-1:0]   br_offset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        cycle_cnt,
  output logic [15:0]        instr_cnt
`endif
);

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  fetch_state_t       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    next_pc;
  logic               start_prev;
  logic               held;
  logic [INSTR_W-1:0] instr_q;
  logic               launch;
  logic               advance;

  assign launch    = (state == IDLE && start) || (state == HALTED && start && !start_prev);
  assign advance   = (state == RUN) && !stall && !halt_req;
  assign imem_addr = launch ? START_ADDR : pc;

  // The ROM keeps reading the held address during a stall, so the displayed word comes from instr_q.
  assign instr = !instr_valid ? '0 : (held ? instr_q : imem_rdata);

  fetch_next_pc #(
    .PC_W     (PC_W),
    .OFF_W    (OFF_W),
    .START_PC (START_PC)
  ) u_next_pc (
    .launch    (launch),
    .advance   (advance),
    .redirect  (br_taken),
    .br_abs    (br_abs),
    .pc        (pc),
    .instr_pc  (instr_pc),
    .br_target (br_target),
    .br_offset (br_offset),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      halt        <= 1'b0;
      start_prev  <= 1'b0;
      held        <= 1'b0;
      instr_q     <= '0;
    end else begin
      start_prev <= start;
      held       <= (state == RUN) && stall;
      instr_q    <= instr;
      pc         <= next_pc;
      case (state)
        IDLE, HALTED: begin
          if (launch) begin
            state       <= RUN;
            halt        <= 1'b0;
            instr_valid <= 1'b1;
            instr_pc    <= START_ADDR;
          end
        end
        RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state       <= HALTED;
              halt        <= 1'b1;
              instr_valid <= 1'b0;
            end else begin
              instr_valid <= !br_taken;
              instr_pc    <= pc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || launch) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state == RUN) begin
      if (cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
      if (instr_valid && !stall && instr_cnt != 16'hFFFF) instr_cnt <= instr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decode/execute datapath inside top_level.
- Owns the program counter and drives the synchronous instruction ROM.
- Delivers one 9-bit instruction per cycle with a valid flag, and implements the start/halt run-control seen at the top_level boundary.
- Absorbs branch redirects and downstream stalls.

Parameters:
PC_W, 8, program counter / ROM address width (ROM depth 2^PC_W)
INSTR_W, 9, instruction width
START_PC, 0, PC loaded when a run begins
OFF_W, 6, signed relative-branch offset width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  run request; level-sampled, rising edge re-arms after halt
halt_req  input  1  downstream decoded a halt instruction
stall  input  1  downstream cannot accept; hold PC and outputs
br_taken  input  1  branch redirect this cycle
br_abs  input  1  1 = absolute target, 0 = PC-relative
br_target  input  PC_W  absolute branch target
br_offset  input  OFF_W  signed offset, added to PC of branching instruction
imem_addr  output  PC_W  ROM address (ROM returns data the next cycle)
imem_rdata  input  INSTR_W  ROM read data
instr  output  INSTR_W  fetched instruction to decode
instr_valid  output  1  instr holds a valid, non-squashed instruction
instr_pc  output  PC_W  PC of instr
halt  output  1  processor halted (mirrors top_level halt)

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset (rst_n=0 at a clk edge, in any state, including mid-run): state=IDLE, pc=START_PC, imem_addr=START_PC, instr=0, instr_valid=0, instr_pc=0, halt=0, start edge tracker=0.
- IDLE -> RUN when start=1. imem_addr=START_PC in that cycle; first instr_valid=1 appears 1 cycle later with instr_pc=START_PC.
- RUN, no stall/branch: imem_addr increments by 1 per cycle; instr/instr_pc lag imem_addr by exactly 1 cycle.
- Wrap: PC increments mod 2^PC_W, so 2^PC_W-1 is followed by 0. No error flag.
- stall=1: imem_addr, instr, instr_valid, instr_pc all hold. br_taken and halt_req are ignored while stall=1; downstream must hold them until stall drops.
- br_taken=1 (stall=0):
  - Next imem_addr = br_target if br_abs=1, else instr_pc + sign-extended br_offset, mod 2^PC_W.
  - The in-flight fetch is squashed: instr_valid=0 for exactly 1 cycle.
  - The target instruction is valid 2 cycles after the br_taken cycle.
- halt_req=1 (stall=0) has priority over a simultaneous br_taken. Next state is HALTED: halt=1, instr_valid=0, PC frozen at its current value.
- HALTED: halt stays 1. Leave only on a start rising edge, i.e. start seen 0 then 1; start held high through the halt does not restart. The transition reloads pc=START_PC, clears halt and behaves like IDLE->RUN.
- start deasserting during RUN has no effect.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: adds output ports cycle_cnt (16) and instr_cnt (16).
  - cycle_cnt counts clocks spent in RUN.
  - instr_cnt counts cycles with instr_valid=1 and stall=0.
  - Both saturate at 16'hFFFF, clear on reset and on every run launch, and freeze in HALTED.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- fetch_pkg: fetch_state_t enum (IDLE/RUN/HALTED), default widths PC_W/INSTR_W/OFF_W as localparams, and the START_PC default.
- One sub-module, fetch_next_pc: combinational next-PC mux covering increment, absolute branch, relative branch, hold and reload, with wrap and sign extension. The FSM and pipeline register stay in fetch_unit.

Test Plan:
- Reset then start=1 at cycle 2 with ROM[i]=i+1: imem_addr 0,1,2,... from cycle 2; instr=1 with instr_pc=0 and instr_valid=1 at cycle 3, then instr=2 at cycle 4.
- PC=255 (PC_W=8), free run: imem_addr goes 255 -> 0; instr_pc of the following valid instr = 0.
- br_taken with br_abs=0, br_offset=-3 (6'b111101) at instr_pc=10: one cycle instr_valid=0, then instr_pc=7.
- br_taken with br_abs=1, br_target=8'h40 while stall=1 for 2 cycles: outputs frozen, branch ignored. When the bench presents the branch again after stall=0: instr_pc=0x40 two cycles later.
- halt_req and br_taken in the same cycle at instr_pc=20: halt=1, instr_valid=0, no redirect. Hold start=1: stays HALTED. start 0 then 1: restarts at instr_pc=0 after 1 cycle.
- rst_n=0 for one cycle mid-RUN at PC=37: next cycle state IDLE, imem_addr=0, halt=0, instr_valid=0. With FETCH_PERF_CNT_EN defined, cycle_cnt=instr_cnt=0.
